// File: rtl/wb_gpio_pinmux_if.sv
// Wishbone classic slave bundle for the GPIO pin-mux block.
interface wb_gpio_pinmux_if;
    logic [2:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_gpio_pinmux.sv
// WIDTH-pin GPIO block: per-pin GPIO/alternate-function mux, synchronised inputs and
// edge interrupts, programmed over a Wishbone slave port.
module wb_gpio_pinmux #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] OE_RESET    = '0,
    parameter logic [WIDTH-1:0] ALT_RESET   = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    wb_gpio_pinmux_if.slave      wb,
    output logic                 irq,
    input  logic [WIDTH-1:0]     pad_i,
    output logic [WIDTH-1:0]     pad_o,
    output logic [WIDTH-1:0]     pad_oe,
    input  logic [WIDTH-1:0]     alt_o,
    input  logic [WIDTH-1:0]     alt_oe,
    output logic [WIDTH-1:0]     alt_i
);

    logic [WIDTH-1:0]     out_q, oe_q, alt_q, rise_en_q, fall_en_q;
    logic [WIDTH-1:0]     in_w, stat_w, wmask, wdat, clr, rsel;
    logic [31:0]          bmask;
    logic                 req, wr, armed;
    logic [SYNC_STAGES:0] arm_pipe;

    // One access per request; the ack cycle itself never starts a new one.
    assign req   = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign wr    = req & wb.wb_we_i;
    assign bmask = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                    {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
    assign wmask = WIDTH'(bmask);
    assign wdat  = WIDTH'(wb.wb_dat_i & bmask);
    assign clr   = (wr && wb.wb_adr_i == 3'd6) ? wdat : '0;

    always_comb begin
        rsel = '0;
        case (wb.wb_adr_i)
            3'd0:    rsel = in_w;
            3'd1:    rsel = out_q;
            3'd2:    rsel = oe_q;
            3'd3:    rsel = alt_q;
            3'd4:    rsel = rise_en_q;
            3'd5:    rsel = fall_en_q;
            3'd6:    rsel = stat_w;
            default: rsel = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q     <= OUT_RESET;
            oe_q      <= OE_RESET;
            alt_q     <= ALT_RESET;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (wr) begin
            case (wb.wb_adr_i)
                3'd1:    out_q     <= (out_q     & ~wmask) | wdat;
                3'd2:    oe_q      <= (oe_q      & ~wmask) | wdat;
                3'd3:    alt_q     <= (alt_q     & ~wmask) | wdat;
                3'd4:    rise_en_q <= (rise_en_q & ~wmask) | wdat;
                3'd5:    fall_en_q <= (fall_en_q & ~wmask) | wdat;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
        end else begin
            wb.wb_ack_o <= req;
            wb.wb_dat_o <= req ? 32'(rsel) : 32'd0;
        end
    end

    // Edge detection stays off until the sync chain and prev hold real pad data.
    always_ff @(posedge clock) begin
        if (reset) arm_pipe <= '0;
        else       arm_pipe <= {arm_pipe[SYNC_STAGES-1:0], 1'b1};
    end
    assign armed = arm_pipe[SYNC_STAGES];

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        logic [SYNC_STAGES-1:0] sync;
        logic                   prev, stat, hit;

        assign hit = armed & ((in_w[i] & ~prev & rise_en_q[i]) |
                              (~in_w[i] & prev & fall_en_q[i]));

        // A new edge beats a same-cycle W1C so no interrupt is lost.
        always_ff @(posedge clock) begin
            if (reset) begin
                sync <= '0;
                prev <= 1'b0;
                stat <= 1'b0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], pad_i[i]};
                prev <= in_w[i];
                stat <= (stat & ~clr[i]) | hit;
            end
        end

        assign in_w[i]   = sync[SYNC_STAGES-1];
        assign stat_w[i] = stat;
        assign pad_o[i]  = alt_q[i] ? alt_o[i]  : out_q[i];
        assign pad_oe[i] = alt_q[i] ? alt_oe[i] : oe_q[i];
    end

    assign irq   = |stat_w;
    assign alt_i = in_w;

endmodule

// File: tb/tb_wb_gpio_pinmux.sv
// Randomised scoreboard bench for wb_gpio_pinmux against a cycle-level reference model.
module tb_wb_gpio_pinmux;
    localparam int W = 8;
    localparam int S = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         irq;
    logic [W-1:0] pad_i, pad_o, pad_oe, alt_o, alt_oe, alt_i;
    bit           run = 1'b0;
    int           total = 0;
    int           bad = 0;

    always #5 clock = ~clock;

    wb_gpio_pinmux_if wb();

    wb_gpio_pinmux #(
        .WIDTH(W), .SYNC_STAGES(S),
        .OUT_RESET(8'h00), .OE_RESET(8'h00), .ALT_RESET(8'h02)
    ) dut (
        .clock(clock), .reset(reset), .wb(wb), .irq(irq),
        .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe),
        .alt_o(alt_o), .alt_oe(alt_oe), .alt_i(alt_i)
    );

    typedef struct { bit rd; logic [31:0] dat; } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: register file plus a pad history; IN is the pad value
    // sampled S edges ago, detection allowed once S+1 edges have passed since reset.
    logic [W-1:0] m_out, m_oe, m_alt, m_rise, m_fall, m_stat, m_in, m_prev;
    logic [W-1:0] pad_hist[$];
    logic         m_ack;
    int           since_rst;
    logic [31:0]  md_bm, md_wd;
    logic [W-1:0] md_rd, md_ev, md_clr, md_wm, md_wv;
    bit           md_req;

    always @(posedge clock) begin
        if (reset) begin
            m_out = 8'h00; m_oe = 8'h00; m_alt = 8'h02;
            m_rise = '0; m_fall = '0; m_stat = '0; m_in = '0; m_prev = '0;
            m_ack = 1'b0; since_rst = 0;
            pad_hist.delete();
            repeat (S) pad_hist.push_back('0);
            sbq.delete();
        end else begin
            md_req = wb.wb_cyc_i && wb.wb_stb_i && !m_ack;
            for (int b = 0; b < 4; b++) md_bm[b*8 +: 8] = {8{wb.wb_sel_i[b]}};
            md_wd = wb.wb_dat_i & md_bm;
            md_wm = md_bm[W-1:0];
            md_wv = md_wd[W-1:0];
            case (wb.wb_adr_i)
                3'd0: md_rd = m_in;
                3'd1: md_rd = m_out;
                3'd2: md_rd = m_oe;
                3'd3: md_rd = m_alt;
                3'd4: md_rd = m_rise;
                3'd5: md_rd = m_fall;
                3'd6: md_rd = m_stat;
                default: md_rd = '0;
            endcase
            if (md_req) sbq.push_back('{!wb.wb_we_i, {24'd0, md_rd}});
            md_ev = '0;
            if (since_rst >= S + 1)
                md_ev = (m_in & ~m_prev & m_rise) | (~m_in & m_prev & m_fall);
            md_clr = (md_req && wb.wb_we_i && wb.wb_adr_i == 3'd6) ? md_wv : '0;
            m_stat = (m_stat & ~md_clr) | md_ev;
            if (md_req && wb.wb_we_i) begin
                case (wb.wb_adr_i)
                    3'd1: m_out  = (m_out  & ~md_wm) | md_wv;
                    3'd2: m_oe   = (m_oe   & ~md_wm) | md_wv;
                    3'd3: m_alt  = (m_alt  & ~md_wm) | md_wv;
                    3'd4: m_rise = (m_rise & ~md_wm) | md_wv;
                    3'd5: m_fall = (m_fall & ~md_wm) | md_wv;
                    default: ;
                endcase
            end
            m_ack  = md_req;
            m_prev = m_in;
            pad_hist.push_front(pad_i);
            void'(pad_hist.pop_back());
            m_in = pad_hist[S-1];
            if (since_rst < 1000) since_rst++;
        end
    end

    // Monitor: pops one expectation per bus request and checks pins every cycle.
    always @(negedge clock) begin
        if (run) begin
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("ack", {31'd0, wb.wb_ack_o}, 32'd1);
                if (mon_e.rd && wb.wb_ack_o) chk("rdata", wb.wb_dat_o, mon_e.dat);
            end else begin
                chk("idle_ack", {31'd0, wb.wb_ack_o}, 32'd0);
            end
            chk("pad_o",  {24'd0, pad_o},  {24'd0, (m_alt & alt_o)  | (~m_alt & m_out)});
            chk("pad_oe", {24'd0, pad_oe}, {24'd0, (m_alt & alt_oe) | (~m_alt & m_oe)});
            chk("irq",    {31'd0, irq},    {31'd0, |m_stat});
            chk("alt_i",  {24'd0, alt_i},  {24'd0, m_in});
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic bus(input logic [2:0] a, input bit we, input logic [31:0] d,
                       input logic [3:0] sel, input int hold = 1);
        wb.wb_adr_i = a; wb.wb_we_i = we; wb.wb_dat_i = d; wb.wb_sel_i = sel;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        repeat (hold) tick();
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [2:0] a);
        bus(a, 1'b0, $urandom, 4'($urandom));
    endtask

    initial begin
        reset = 1'b1;
        wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0; wb.wb_we_i = 1'b0;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        pad_i = '0; alt_o = '0; alt_oe = 8'hFF;
        tick();
        run = 1'b1;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state and boot alternate routing of pin 1
        repeat (3) tick();
        rd(3'd1); rd(3'd2); rd(3'd3); rd(3'd6); rd(3'd7);

        // Byte-gated writes, sel=0 no-op, back-to-back strobe
        bus(3'd1, 1'b1, 32'hFFFF_FFA5, 4'b0001);
        bus(3'd2, 1'b1, 32'h0000_00FF, 4'b1111);
        bus(3'd1, 1'b1, 32'h0000_0000, 4'b0000);
        rd(3'd1);
        bus(3'd0, 1'b1, 32'hFFFF_FFFF, 4'b1111);
        bus(3'd7, 1'b1, 32'hFFFF_FFFF, 4'b1111);
        bus(3'd2, 1'b0, 32'd0, 4'b1111, 4);

        // Rising edge on pin 0, then W1C
        bus(3'd4, 1'b1, 32'h1, 4'b0001);
        pad_i[0] = 1'b1;
        repeat (4) tick();
        rd(3'd6);
        bus(3'd6, 1'b1, 32'h1, 4'b0001);
        rd(3'd6);

        // Falling edge on pin 3 coinciding with its clear
        bus(3'd5, 1'b1, 32'h8, 4'b0001);
        pad_i[3] = 1'b1; repeat (4) tick();
        pad_i[3] = 1'b0; repeat (4) tick();
        pad_i[3] = 1'b1; repeat (4) tick();
        pad_i[3] = 1'b0; tick(); tick();
        bus(3'd6, 1'b1, 32'h8, 4'b0001);
        rd(3'd6);
        bus(3'd6, 1'b1, 32'h8, 4'b0001);
        rd(3'd6);

        // Alternate function follows alt_o, then back to OUT
        bus(3'd3, 1'b1, 32'h2, 4'b0001);
        bus(3'd1, 1'b1, 32'h0, 4'b0001);
        for (int k = 0; k < 6; k++) begin
            alt_o = 8'($urandom); alt_oe = 8'($urandom);
            tick();
        end
        bus(3'd3, 1'b1, 32'h0, 4'b0001);
        repeat (2) tick();

        // Pads high through reset release with RISE_EN written immediately
        pad_i = 8'hFF;
        reset = 1'b1;
        wb.wb_adr_i = 3'd4; wb.wb_we_i = 1'b1; wb.wb_dat_i = 32'hFF; wb.wb_sel_i = 4'hF;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        repeat (6) tick();
        rd(3'd6);
        rd(3'd4);

        // Random traffic
        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 3) == 0) pad_i = pad_i ^ 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                alt_o = 8'($urandom); alt_oe = 8'($urandom);
            end
            case ($urandom_range(0, 4))
                0:       tick();
                1:       rd(3'($urandom));
                default: bus(3'($urandom), 1'($urandom), $urandom, 4'($urandom),
                             int'($urandom_range(1, 3)));
            endcase
        end

        repeat (4) tick();
        chk("sb_drain", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
